// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requesting unit and the serial adder sequencer.
// The sub select exists only when SERIAL_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef SERIAL_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit add over one shared full-adder cell, LSB first; done pulses W cycles after start is accepted.
// start is honoured only in IDLE (no queueing, no backpressure); SERIAL_SUB_EN adds the A-B mode.
module serial_adder_ctrl #(
  parameter int W = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     res_sh;
  logic [W-1:0]     sum_r;
  logic             carry;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             fa_s;
  logic             fa_c;
  logic [W-1:0]     b_init;
  logic             carry_init;

  // busy/done are flopped from the next state so they leave the block as clean register outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt != IDLE);
      done_r <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE:    load = bus.start;
      RUN:     step = 1'b1;
      default: ;
    endcase
  end

  assign last = (cnt == CNT_W'(W - 1));
  assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);

`ifdef SERIAL_SUB_EN
  // A + ~B + 1: carry-out of 1 means no borrow
  assign b_init     = bus.sub ? ~bus.b : bus.b;
  assign carry_init = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_init     = bus.b;
  assign carry_init = bus.cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (load) begin
      a_sh   <= bus.a;
      b_sh   <= b_init;
      res_sh <= '0;
      carry  <= carry_init;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {fa_s, res_sh[W-1:1]};
      carry  <= fa_c;
      if (last) begin
        sum_r  <= {fa_s, res_sh[W-1:1]};
        cout_r <= fa_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule
